// File: rtl/div_32bit.sv
// Sequential 32-bit restoring divider (signed/unsigned), one quotient bit per clock.
// The trial subtraction goes through a 32-bit ripple-carry adder fed with the inverted divisor.

module rca_32bit (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);
  always_comb begin
    logic c;
    c = cin_i;
    for (int i = 0; i < 32; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c;
      c        = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    cout_o = c;
  end
endmodule

module div_32bit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [32:0] rem_q, rem_d;     // partial remainder
  logic [31:0] dvd_q, dvd_d;     // dividend magnitude, becomes quotient as bits shift in
  logic [31:0] dsr_q, dsr_d;     // divisor magnitude
  logic [31:0] raw_q, raw_d;     // raw dividend, returned as remainder on divide-by-zero
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_q_q, neg_q_d, neg_r_q, neg_r_d, dz_q, dz_d;
  logic [31:0] quot_q, quot_d, remo_q, remo_d;
  logic        done_q, done_d, dbz_q, dbz_d;

  logic [32:0] shifted;
  logic [31:0] diff;
  logic        cout, no_borrow;

  assign shifted = {rem_q[31:0], dvd_q[31]};

  rca_32bit u_rca (
    .a_i    (shifted[31:0]),
    .b_i    (~dsr_q),
    .cin_i  (1'b1),
    .sum_o  (diff),
    .cout_o (cout)
  );

  // Bit 32 of the shifted remainder set means it already exceeds any 32-bit divisor.
  assign no_borrow = shifted[32] | cout;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    raw_d   = raw_q;
    cnt_d   = cnt_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    dz_d    = dz_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d   = (is_signed && dividend[31]) ? -dividend : dividend;
          dsr_d   = (is_signed && divisor[31])  ? -divisor  : divisor;
          raw_d   = dividend;
          neg_q_d = is_signed && (dividend[31] ^ divisor[31]);
          neg_r_d = is_signed && dividend[31];
          dz_d    = (divisor == 32'd0);
          rem_d   = 33'd0;
          cnt_d   = 5'd0;
          state_d = CALC;
        end
      end
      CALC: begin
        rem_d = no_borrow ? {1'b0, diff} : shifted;
        dvd_d = {dvd_q[30:0], no_borrow};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIX;
      end
      FIX: begin
        if (dz_q) begin
          quot_d = 32'hFFFF_FFFF;
          remo_d = raw_q;
        end else begin
          quot_d = neg_q_q ? -dvd_q : dvd_q;
          remo_d = neg_r_q ? -rem_q[31:0] : rem_q[31:0];
        end
        dbz_d   = dz_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= 33'd0;
      dvd_q   <= 32'd0;
      dsr_q   <= 32'd0;
      raw_q   <= 32'd0;
      cnt_q   <= 5'd0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      dz_q    <= 1'b0;
      quot_q  <= 32'd0;
      remo_q  <= 32'd0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      raw_q   <= raw_d;
      cnt_q   <= cnt_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      dz_q    <= dz_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;
endmodule
